dbf_coarse_delay: RTL and testbench
===================================

Name: dbf_coarse_delay

Overview:
- Per-channel integer-sample delay line for the digital beamformer.
- Sits directly upstream of the fine-delay MMSE interpolator.
- Delays the ADC sample stream by a programmable whole number of valid samples (0..2^DLY_WD-1).
- Presents the result as datain/datain_valid to the fine stage, which then applies the fractional part.

Parameters:
- INPUT_WD, 12, sample width in bits, two's complement. Taken from the shared param.h.
- DLY_WD, 6, coarse delay field width. Buffer depth is DEPTH = 2^DLY_WD.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- din, input, INPUT_WD, signed input sample.
- din_valid, input, 1, din is valid in this cycle.
- coarse_dly, input, DLY_WD, requested integer delay, in samples.
- dly_load, input, 1, one-cycle strobe that captures coarse_dly.
- dout, output, INPUT_WD, signed delayed sample; drives the fine stage datain.
- dout_valid, output, 1, dout is valid; drives the fine stage datain_valid.
- dly_busy, output, 1, high while the block is not in RUN.

Behaviour:
- Reset: the following are all cleared to 0:
  - dout, dout_valid, dly_busy=0.
  - Internal registers active_dly, wr_ptr and fill_cnt.
  - State goes to IDLE.
- Buffer contents are not reset.
- Write path: each cycle with din_valid=1, din is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap at DEPTH-1 -> 0).
- fill_cnt increments on each din_valid and saturates at DEPTH-1.
- Read address: rd_addr = wr_ptr - active_dly, modulo DEPTH. The read is combinational and uses the pre-increment wr_ptr.
- active_dly=0: bypass the buffer; the output sample is din itself.
- Latency: 1 clk from a din_valid cycle to the matching dout_valid. dout and dout_valid are registered.
- dout_valid: set to 1 in the cycle after din_valid=1 when fill_cnt >= active_dly. Otherwise set to 0.
- dout: forced to 0 whenever dout_valid=0, matching the fine stage's zeroing convention.
- States:
  - IDLE: after reset. dly_busy=0.
    - Go to PRIME on the first dly_load.
    - Samples arriving in IDLE use active_dly=0 (pass-through, valid).
  - PRIME: entered on any dly_load. dly_busy=1.
    - Go to RUN on the first din_valid cycle with fill_cnt >= active_dly.
  - RUN: dly_busy=0.
    - A dly_load returns to PRIME.
    - fill_cnt is not cleared, so history already in the buffer is reused. Re-prime time is max(0, new_dly - fill_cnt) samples.
- dly_load capture: active_dly <= coarse_dly, effective from the next clk.
- dly_load coincident with din_valid: the coincident sample uses the old active_dly.
- Back-to-back dly_load: the last one wins. The state stays in PRIME.
- din_valid low: no write, no pointer or counter change, dout_valid=0 in the following cycle.
- Asserting reset mid-stream: outputs go to 0 immediately (asynchronously). fill_cnt=0, so a full re-prime is required after release.
- Width rule: pointer arithmetic is exactly DLY_WD bits unsigned with wrap. No sample arithmetic is performed; dout is a bit-exact copy of din.

Optional Feature:
- Macro: DBF_CD_ZERO_PRIME_EN.
- Defined: during PRIME, every din_valid produces dout_valid=1 with dout=0. Downstream therefore sees an uninterrupted valid stream with zero-padded history, and beam timing stays fixed across delay changes.
- Undefined: dout_valid is suppressed during PRIME, as described above.
- dly_busy and all state transitions are identical in both builds.

Decomposition:
- Shared package dbf_cd_pkg:
  - DEPTH constant.
  - State encoding: IDLE=2'd0, PRIME=2'd1, RUN=2'd2.
  - INPUT_WD still comes from param.h.
- Sub-module dbf_cd_ram:
  - DEPTH x INPUT_WD simple dual-port array.
  - Synchronous write, combinational read.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
- The top level holds the pointers, fill counter, FSM and output register.

Test Plan:
- Reset release, then din=1,2,3... continuously with no dly_load -> dout_valid rises 1 clk after the first din_valid and dout=1,2,3 with 1 clk latency; dly_busy=0.
- After reset, dly_load with coarse_dly=5, then stream din=10,11,12... -> dly_busy=1 for 5 samples; the first dout_valid carries 10, aligned to the din=15 cycle (+1 clk); then RUN, dly_busy=0. With DBF_CD_ZERO_PRIME_EN, the first 5 outputs are valid zeros.
- In RUN with delay 5 and fill_cnt saturated, dly_load coarse_dly=63 -> no dout_valid gap (history is sufficient) and the output jumps to the sample 63 back. Over 200 samples, check wrap-around correctness.
- din_valid toggling 1-0-1-0 with delay 3 -> delay counted in valid samples only; dout=0 and dout_valid=0 in the cycles after a gap.
- dly_load coincident with din_valid=1 (old delay 2, new delay 4) -> that sample uses delay 2, the next uses delay 4. The last of two back-to-back loads wins.
- reset_n pulsed low mid-stream -> dout, dout_valid and dly_busy are 0 immediately. After release, delay 0 pass-through resumes with fill_cnt restarting from 0.

Source files
------------

// File: rtl/dbf_cd_pkg.sv
// Shared constants and FSM encoding for the beamformer coarse-delay block.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// INPUT_WD mirrors the value held in the shared beamformer parameter header.
package dbf_cd_pkg;

  localparam int INPUT_WD = 12;
  localparam int DLY_WD   = 6;
  localparam int DEPTH    = 1 << DLY_WD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } cd_state_e;

endpackage

// File: rtl/dbf_coarse_delay_if.sv
// Sample stream, delay-control and status bundle for dbf_coarse_delay.
// Latency: n/a (signal grouping only).
// Backpressure: none; the stream is valid-only, with no ready.
// master: drives din/din_valid/coarse_dly/dly_load, receives dout/dout_valid/dly_busy.
// slave : the delay block itself.
interface dbf_coarse_delay_if;

  logic signed [dbf_cd_pkg::INPUT_WD-1:0] din;
  logic                                   din_valid;
  logic        [dbf_cd_pkg::DLY_WD-1:0]   coarse_dly;
  logic                                   dly_load;
  logic signed [dbf_cd_pkg::INPUT_WD-1:0] dout;
  logic                                   dout_valid;
  logic                                   dly_busy;

  modport master (
    output din, din_valid, coarse_dly, dly_load,
    input  dout, dout_valid, dly_busy
  );

  modport slave (
    input  din, din_valid, coarse_dly, dly_load,
    output dout, dout_valid, dly_busy
  );

endinterface

// File: rtl/dbf_cd_ram.sv
// DEPTH x INPUT_WD simple dual-port sample buffer: synchronous write, combinational read.
// Latency: write visible to the read port on the cycle after the write edge.
// Backpressure: none.
// Ports: clk, we, waddr, wdata (write side); raddr, rdata (read side). Contents are never reset.
module dbf_cd_ram
  import dbf_cd_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [DLY_WD-1:0]   waddr,
  input  logic [INPUT_WD-1:0] wdata,
  input  logic [DLY_WD-1:0]   raddr,
  output logic [INPUT_WD-1:0] rdata
);

  logic [INPUT_WD-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dbf_coarse_delay.sv
// Per-channel integer-sample delay line feeding the fine-delay interpolator.
// Latency: 1 clk from a din_valid cycle to its dout_valid; delay counted in valid samples.
// Backpressure: none; output valid is withheld while history is short (PRIME).
// Ports: clk, reset_n (async active-low), cd (slave: din/din_valid/coarse_dly/dly_load in,
//        dout/dout_valid/dly_busy out).
// Build option: DBF_CD_ZERO_PRIME_EN makes PRIME emit valid zero samples instead of gaps.
module dbf_coarse_delay
  import dbf_cd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  dbf_coarse_delay_if.slave cd
);

  localparam logic [DLY_WD-1:0] FILL_MAX = DLY_WD'(DEPTH - 1);

  cd_state_e             r_state;
  cd_state_e             w_next_state;
  logic [DLY_WD-1:0]     r_active_dly;
  logic [DLY_WD-1:0]     r_wr_ptr;
  logic [DLY_WD-1:0]     r_fill_cnt;
  logic [INPUT_WD-1:0]   r_dout;
  logic                  r_dout_valid;
  logic                  r_dly_busy;

  logic [DLY_WD-1:0]     w_rd_addr;
  logic [INPUT_WD-1:0]   w_rdata;
  logic [INPUT_WD-1:0]   w_sample;
  logic                  w_hist_ok;
  logic                  w_pad;

  dbf_cd_ram u_ram (
    .clk   (clk),
    .we    (cd.din_valid),
    .waddr (r_wr_ptr),
    .wdata (cd.din),
    .raddr (w_rd_addr),
    .rdata (w_rdata)
  );

  // Read uses the pre-increment write pointer; wraps naturally in DLY_WD bits.
  assign w_rd_addr = r_wr_ptr - r_active_dly;
  // Delay 0 would read the slot being written this cycle, so bypass the buffer.
  assign w_sample  = (r_active_dly == '0) ? cd.din : w_rdata;
  assign w_hist_ok = (r_fill_cnt >= r_active_dly);

`ifdef DBF_CD_ZERO_PRIME_EN
  assign w_pad = (r_state == PRIME);
`else
  assign w_pad = 1'b0;
`endif

  // A load always (re)enters PRIME, even if it coincides with the priming sample.
  always_comb begin
    w_next_state = r_state;
    if (cd.dly_load) begin
      w_next_state = PRIME;
    end else if (r_state == PRIME && cd.din_valid && w_hist_ok) begin
      w_next_state = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_active_dly <= '0;
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dly_busy   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_dly_busy <= (w_next_state == PRIME);
      // New delay applies from the next cycle; a coincident sample still uses the old one.
      if (cd.dly_load) begin
        r_active_dly <= cd.coarse_dly;
      end
      if (cd.din_valid) begin
        r_wr_ptr <= r_wr_ptr + DLY_WD'(1);
        if (r_fill_cnt != FILL_MAX) begin
          r_fill_cnt <= r_fill_cnt + DLY_WD'(1);
        end
      end
      r_dout_valid <= cd.din_valid && (w_hist_ok || w_pad);
      r_dout       <= (cd.din_valid && w_hist_ok) ? w_sample : '0;
    end
  end

  assign cd.dout       = r_dout;
  assign cd.dout_valid = r_dout_valid;
  assign cd.dly_busy   = r_dly_busy;

endmodule

// File: tb/tb_dbf_coarse_delay.sv
// Directed self-checking bench for dbf_coarse_delay.
// Latency: outputs sampled 1 ns after the edge that registers each driven sample.
// Backpressure: n/a; fixed-length stimulus, no open-ended waits.
module tb_dbf_coarse_delay;

`ifdef DBF_CD_ZERO_PRIME_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  dbf_coarse_delay_if cd();

  dbf_coarse_delay dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cd      (cd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int d, input int busy);
    chk({tag, "_vld"},  cd.dout_valid, v);
    chk({tag, "_dout"}, cd.dout,       d);
    chk({tag, "_busy"}, cd.dly_busy,   busy);
  endtask

  // Drive one cycle of inputs on the falling edge, return just after the rising edge.
  task automatic tick(input bit v, input int d, input bit ld, input int dly);
    @(negedge clk);
    cd.din        = d[11:0];
    cd.din_valid  = v;
    cd.dly_load   = ld;
    cd.coarse_dly = dly[5:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cd.din_valid = 1'b0;
    cd.dly_load  = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    reset_n      = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    cd.din        = '0;
    cd.din_valid  = 1'b0;
    cd.dly_load   = 1'b0;
    cd.coarse_dly = '0;

    // Reset state
    #12;
    chk_out("rst", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // No load: pass-through, 1 clk latency, full-scale values bit-exact
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, k, 1'b0, 0);
      chk_out("pass", 1, k, 0);
    end
    tick(1'b1, -2048, 1'b0, 0);
    chk_out("pass_min", 1, -2048, 0);
    tick(1'b1, 2047, 1'b0, 0);
    chk_out("pass_max", 1, 2047, 0);
    tick(1'b0, 0, 1'b0, 0);
    chk_out("pass_gap", 0, 0, 0);

    // Load delay 5 from empty history, then stream past fill saturation
    do_reset();
    tick(1'b0, 0, 1'b1, 5);
    chk_out("ld5", 0, 0, 1);
    for (int k = 0; k < 80; k++) begin
      tick(1'b1, 10 + k, 1'b0, 0);
      if (k < 5) chk_out("prime5", ZP, 0, 1);
      else       chk_out("run5", 1, 5 + k, 0);
    end

    // Jump to maximum delay with saturated history: no gap, 200 samples across wraps
    tick(1'b0, 0, 1'b1, 63);
    chk_out("ld63", 0, 0, 1);
    for (int k = 0; k < 200; k++) begin
      tick(1'b1, 90 + k, 1'b0, 0);
      chk_out("run63", 1, 27 + k, 0);
    end

    // Alternating valid/gap with delay 3: delay counts valid samples only
    do_reset();
    tick(1'b0, 0, 1'b1, 3);
    for (int j = 0; j < 12; j++) begin
      tick(1'b1, 20 + j, 1'b0, 0);
      if (j < 3) chk_out("tog_prime", ZP, 0, 1);
      else       chk_out("tog_run", 1, 17 + j, 0);
      tick(1'b0, 0, 1'b0, 0);
      chk_out("tog_gap", 0, 0, (j < 3) ? 1 : 0);
    end

    // Load coincident with a sample, then back-to-back loads
    do_reset();
    tick(1'b0, 0, 1'b1, 2);
    for (int j = 0; j < 6; j++) begin
      tick(1'b1, 30 + j, 1'b0, 0);
      if (j < 2) chk_out("co_prime", ZP, 0, 1);
      else       chk_out("co_run", 1, 28 + j, 0);
    end
    tick(1'b1, 36, 1'b1, 4);
    chk_out("co_old", 1, 34, 1);
    tick(1'b1, 37, 1'b0, 0);
    chk_out("co_new", 1, 33, 0);
    tick(1'b0, 0, 1'b1, 7);
    chk_out("b2b_a", 0, 0, 1);
    tick(1'b0, 0, 1'b1, 3);
    chk_out("b2b_b", 0, 0, 1);
    tick(1'b1, 38, 1'b0, 0);
    chk_out("b2b_last", 1, 35, 0);

    // Asynchronous reset mid-stream while outputs and busy are all non-zero
    tick(1'b1, 39, 1'b1, 50);
    chk_out("pre_arst", 1, 36, 1);
    #2;
    cd.din_valid = 1'b0;
    cd.dly_load  = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk_out("arst", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, 40, 1'b0, 0);
    chk_out("post_pass", 1, 40, 0);
    tick(1'b0, 0, 1'b1, 2);
    chk_out("post_ld", 0, 0, 1);
    tick(1'b1, 41, 1'b0, 0);
    chk_out("post_prime", ZP, 0, 1);
    tick(1'b1, 42, 1'b0, 0);
    chk_out("post_run", 1, 40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
